noc_port_arbiter: RTL and testbench
===================================

Name: noc_port_arbiter

Overview:
- Per-output-port arbiter and flow controller for the mesh NoC router.
- Shares one router output port (N/S/E/W/local) among NUM_REQ input requesters using round-robin arbitration.
- Wormhole packet locking: once a packet's head flit is granted, the port stays with that requester until its tail flit.
- Gates flit transfer on a downstream credit counter so the neighbouring router's input buffer cannot overflow.

Parameters:
- DATA_WIDTH, 64, flit width in bits.
- NUM_REQ, 5, number of requesters; index 0..3 = N,S,E,W, index 4 = local.
- CREDITS, 4, downstream buffer depth; initial and maximum credit count.

Ports:
- clk  in  1  clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  requester i has a flit available.
- req_data  in  NUM_REQ*DATA_WIDTH  packed flits; requester i at [i*DATA_WIDTH +: DATA_WIDTH].
- req_tail  in  NUM_REQ  flit from requester i is the last flit of its packet.
- req_ready  out  NUM_REQ  flit from requester i is accepted this cycle.
- out_valid  out  1  registered flit valid, one cycle per flit.
- out_data  out  DATA_WIDTH  registered flit data.
- out_tail  out  1  registered tail flag.
- grant_id  out  clog2(NUM_REQ)  index of the requester whose flit is currently on out_data.
- credit_return  in  1  downstream freed one buffer slot.
- credit_count  out  clog2(CREDITS+1)  current available credits.
- busy  out  1  port is locked mid-packet.
- err_credit_overflow  out  1  sticky error flag.

Behaviour:
- Reset values:
  - out_valid=0, out_data=0, out_tail=0, grant_id=0.
  - credit_count=CREDITS, busy=0, err_credit_overflow=0.
  - Internal state: state=IDLE, last_grant=NUM_REQ-1, so requester 0 has first priority.
- Transfer (requester i):
  - A transfer occurs when req_valid[i] && req_ready[i] at a rising edge.
  - Exactly one req_ready bit may be high in any cycle.
- Winner selection (IDLE):
  - winner = first i with req_valid[i]=1, scanning (last_grant+1) mod NUM_REQ upward with wrap-around.
  - req_ready[winner] = (credit_count>0); all other req_ready bits are 0.
  - req_ready is combinational from req_valid, state and credit_count.
- Grant holding (LOCKED): req_ready[owner] = (credit_count>0); all others are 0.
- State transitions:
  - IDLE -> LOCKED on a head-flit transfer with req_tail=0; owner and last_grant are set to that requester.
  - IDLE stays IDLE on a single-flit packet (tail=1); last_grant is still updated.
  - LOCKED -> IDLE on a transfer from owner with req_tail=1.
  - Owner deasserting req_valid while LOCKED creates a bubble. The lock is held and no other requester is served.
- Latency:
  - The transferred flit appears on out_data/out_tail/grant_id with out_valid=1 one cycle after the accepting edge.
  - out_valid=0 in any cycle following no transfer; out_data and grant_id hold their last values.
- busy = (state==LOCKED), registered.
- Credits:
  - A transfer decrements credit_count; credit_return increments it.
  - Both in the same cycle leave the count unchanged.
  - A transfer is impossible at count 0.
  - credit_return when credit_count==CREDITS and no transfer that cycle: count stays CREDITS and err_credit_overflow is set to 1.
  - err_credit_overflow stays high until reset.
- Round-robin fairness: the requester granted a head flit gets lowest priority at the next arbitration.
- Reset mid-packet:
  - Immediately returns to reset values; the partial packet is abandoned and credits are restored to CREDITS.
  - Downstream recovery is outside this block.

Test Plan:
- Reset, then req_valid[4]=1, req_data[4]=0xAA, req_tail[4]=1 -> req_ready[4]=1 the same cycle. Next cycle: out_valid=1, out_data=0xAA, out_tail=1, grant_id=4, credit_count=3.
- All five requesters valid with single-flit packets continuously, credit_return=1 every cycle -> grant_id sequence 0,1,2,3,4,0,1; one flit per cycle; credit_count stays at its post-first-transfer value.
- req0 sends a 3-flit packet (tail on flit 3) while req1 is valid throughout -> flits from 0,0,0 then 1. busy=1 from the cycle after flit 1 until the cycle after flit 3. Insert a req0 valid gap mid-packet -> req1 stays unserved.
- No credit_return, req2 streams 6 single-flit packets -> 4 transfers, then req_ready[2]=0 with credit_count=0. One credit_return pulse -> exactly one more transfer on the following cycle.
- credit_count=1 with a transfer and credit_return in the same cycle -> credit_count stays 1. credit_return at credit_count=4 with no transfer -> stays 4, err_credit_overflow=1, held until reset.
- Assert reset during flit 2 of a 4-flit packet -> all outputs at reset values immediately. After release, a different requester wins per reset priority starting at index 0.

Source files
------------

// File: rtl/noc_port_arbiter.sv
// Output-port arbiter for the mesh NoC router: round-robin head-flit arbitration,
// wormhole locking until the tail flit, and downstream credit-based flow control.
module noc_port_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_REQ    = 5,
    parameter int CREDITS    = 4,
    localparam int GRANT_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int CNT_W     = $clog2(CREDITS + 1)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_tail,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          out_valid,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic                          out_tail,
    output logic [GRANT_W-1:0]            grant_id,
    input  logic                          credit_return,
    output logic [CNT_W-1:0]              credit_count,
    output logic                          busy,
    output logic                          err_credit_overflow
);

    typedef enum logic {IDLE, LOCKED} state_t;

    localparam logic [CNT_W-1:0]   CREDIT_MAX = CNT_W'(CREDITS);
    localparam logic [GRANT_W-1:0] LAST_IDX   = GRANT_W'(NUM_REQ - 1);

    state_t                state_q, state_d;
    logic [GRANT_W-1:0]    owner_q, owner_d;
    logic [GRANT_W-1:0]    last_grant_q, last_grant_d;
    logic [CNT_W-1:0]      credit_q, credit_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_tail_q, out_tail_d;
    logic [GRANT_W-1:0]    grant_q, grant_d;
    logic                  err_q, err_d;

    logic [GRANT_W-1:0]    sel_idx;
    logic                  sel_found;
    logic                  xfer;

    // Requester selection: the lock owner while LOCKED, otherwise the first valid
    // requester scanning upward from the one after the last head-flit grant.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        sel_idx   = owner_q;
        sel_found = 1'b0;
        if (state_q == LOCKED) begin
            sel_found = 1'b1;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!sel_found && req_valid[(int'(last_grant_q) + 1 + k) % NUM_REQ]) begin
                    sel_found = 1'b1;
                    sel_idx   = GRANT_W'((int'(last_grant_q) + 1 + k) % NUM_REQ);
                end
            end
        end

        req_ready = '0;
        if (sel_found && (credit_q != '0)) begin
            req_ready[sel_idx] = 1'b1;
        end
        xfer = req_valid[sel_idx] && req_ready[sel_idx];
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        credit_d     = credit_q;
        err_d        = err_q;
        out_valid_d  = xfer;
        out_data_d   = out_data_q;
        out_tail_d   = out_tail_q;
        grant_d      = grant_q;

        if (xfer) begin
            out_data_d = req_data[int'(sel_idx)*DATA_WIDTH +: DATA_WIDTH];
            out_tail_d = req_tail[sel_idx];
            grant_d    = sel_idx;
            if (state_q == IDLE) begin
                last_grant_d = sel_idx;
                if (!req_tail[sel_idx]) begin
                    state_d = LOCKED;
                    owner_d = sel_idx;
                end
            end else if (req_tail[sel_idx]) begin
                state_d = IDLE;
            end
        end

        // A return with the counter already full means downstream over-reported space.
        if (xfer && !credit_return) begin
            credit_d = credit_q - CNT_W'(1);
        end else if (!xfer && credit_return) begin
            if (credit_q == CREDIT_MAX) begin
                err_d = 1'b1;
            end else begin
                credit_d = credit_q + CNT_W'(1);
            end
        end
    end

    // NOTE: sequential state is written with non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            last_grant_q <= LAST_IDX;
            credit_q     <= CREDIT_MAX;
            err_q        <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_tail_q   <= 1'b0;
            grant_q      <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            credit_q     <= credit_d;
            err_q        <= err_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_tail_q   <= out_tail_d;
            grant_q      <= grant_d;
        end
    end

    assign out_valid           = out_valid_q;
    assign out_data            = out_data_q;
    assign out_tail            = out_tail_q;
    assign grant_id            = grant_q;
    assign credit_count        = credit_q;
    assign busy                = (state_q == LOCKED);
    assign err_credit_overflow = err_q;

endmodule

// File: tb/tb_noc_port_arbiter.sv
// Randomized and directed checking of noc_port_arbiter against a packet-level
// reference model (round-robin list, wormhole lock, credit counter).
module tb_noc_port_arbiter;

    localparam int N = 5;
    localparam int W = 64;
    localparam int C = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [N-1:0]     req_valid = '0;
    logic [N*W-1:0]   req_data = '0;
    logic [N-1:0]     req_tail = '0;
    logic [N-1:0]     req_ready;
    logic             out_valid;
    logic [W-1:0]     out_data;
    logic             out_tail;
    logic [2:0]       grant_id;
    logic             credit_return = 1'b0;
    logic [2:0]       credit_count;
    logic             busy;
    logic             err_credit_overflow;

    noc_port_arbiter #(.DATA_WIDTH(W), .NUM_REQ(N), .CREDITS(C)) dut (
        .clk                 (clk),
        .reset               (reset),
        .req_valid           (req_valid),
        .req_data            (req_data),
        .req_tail            (req_tail),
        .req_ready           (req_ready),
        .out_valid           (out_valid),
        .out_data            (out_data),
        .out_tail            (out_tail),
        .grant_id            (grant_id),
        .credit_return       (credit_return),
        .credit_count        (credit_count),
        .busy                (busy),
        .err_credit_overflow (err_credit_overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    bit         m_locked;
    int         m_owner;
    int         m_last;
    int         m_cred;
    bit         m_err;
    bit         e_valid;
    logic [W-1:0] e_data;
    bit         e_tail;
    int         e_gid;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_locked = 0; m_owner = 0; m_last = N - 1; m_cred = C; m_err = 0;
        e_valid = 0; e_data = '0; e_tail = 0; e_gid = 0;
    endfunction

    // Index the port would serve now, or -1: owner while locked, else round-robin.
    function automatic int served(input logic [N-1:0] v);
        if (m_locked) return m_owner;
        for (int k = 1; k <= N; k++) begin
            if (v[(m_last + k) % N]) return (m_last + k) % N;
        end
        return -1;
    endfunction

    task automatic check_outputs();
        check("out_valid", 64'(out_valid), 64'(e_valid));
        check("out_data", out_data, e_data);
        check("grant_id", 64'(grant_id), 64'(e_gid));
        if (e_valid) check("out_tail", 64'(out_tail), 64'(e_tail));
        check("credit_count", 64'(credit_count), 64'(m_cred));
        check("busy", 64'(busy), 64'(m_locked));
        check("err_overflow", 64'(err_credit_overflow), 64'(m_err));
    endtask

    // One clock cycle: drive at negedge, check ready, clock, check registered outputs.
    task automatic cycle(input logic [N-1:0] v, input logic [N-1:0] t,
                         input logic [N*W-1:0] d, input logic cr);
        int s;
        int x;
        logic [N-1:0] exp_ready;
        req_valid = v; req_tail = t; req_data = d; credit_return = cr;
        #1;
        s = served(v);
        exp_ready = '0;
        if (s >= 0 && m_cred > 0) exp_ready[s] = 1'b1;
        check("req_ready", 64'(req_ready), 64'(exp_ready));
        x = (s >= 0 && exp_ready[s] && v[s]) ? s : -1;

        e_valid = (x >= 0);
        if (x >= 0) begin
            e_data = d[x*W +: W];
            e_tail = t[x];
            e_gid  = x;
            if (!m_locked) begin
                m_last = x;
                if (!t[x]) begin m_locked = 1; m_owner = x; end
            end else if (t[x]) begin
                m_locked = 0;
            end
            if (!cr) m_cred--;
        end else if (cr) begin
            if (m_cred == C) m_err = 1;
            else m_cred++;
        end

        @(posedge clk);
        #1;
        check_outputs();
        @(negedge clk);
    endtask

    // Asynchronous reset asserted away from any clock edge.
    task automatic do_reset();
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        reset = 1'b0;
        req_valid = '0; req_tail = '0; credit_return = 1'b0;
    endtask

    function automatic logic [N*W-1:0] one_data(input int i, input logic [W-1:0] val);
        logic [N*W-1:0] d;
        d = '0;
        d[i*W +: W] = val;
        return d;
    endfunction

    function automatic logic [N*W-1:0] rand_data();
        logic [N*W-1:0] d;
        for (int i = 0; i < N; i++) d[i*W +: W] = {$urandom, $urandom};
        return d;
    endfunction

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs();
        reset = 1'b0;

        // Local single-flit packet.
        cycle(5'b10000, 5'b10000, one_data(4, 64'hAA), 1'b0);
        check("first_gid", 64'(grant_id), 64'd4);
        check("first_data", out_data, 64'hAA);
        check("first_cred", 64'(credit_count), 64'd3);

        // All requesters, single flits, credit returned every cycle.
        for (int i = 0; i < 7; i++) cycle(5'b11111, 5'b11111, rand_data(), 1'b1);

        // 3-flit packet from req0 with a bubble while req1 waits.
        do_reset();
        cycle(5'b00011, 5'b00010, rand_data(), 1'b1);
        cycle(5'b00010, 5'b00010, rand_data(), 1'b1);
        cycle(5'b00010, 5'b00010, rand_data(), 1'b1);
        cycle(5'b00011, 5'b00010, rand_data(), 1'b1);
        cycle(5'b00011, 5'b00011, rand_data(), 1'b1);
        cycle(5'b00010, 5'b00010, rand_data(), 1'b1);

        // Credit exhaustion: req2 streams without returns.
        do_reset();
        for (int i = 0; i < 6; i++) cycle(5'b00100, 5'b00100, rand_data(), 1'b0);
        check("stall_cred", 64'(credit_count), 64'd0);
        cycle(5'b00100, 5'b00100, rand_data(), 1'b1);
        cycle(5'b00100, 5'b00100, rand_data(), 1'b0);
        cycle(5'b00100, 5'b00100, rand_data(), 1'b0);

        // Simultaneous transfer and return at count 1, then overflow.
        do_reset();
        for (int i = 0; i < 3; i++) cycle(5'b01000, 5'b01000, rand_data(), 1'b0);
        cycle(5'b01000, 5'b01000, rand_data(), 1'b1);
        for (int i = 0; i < 4; i++) cycle(5'b00000, 5'b00000, rand_data(), 1'b1);
        check("overflow_flag", 64'(err_credit_overflow), 64'd1);
        for (int i = 0; i < 3; i++) cycle(5'b00001, 5'b00001, rand_data(), 1'b0);

        // Reset mid-packet, then priority restarts from index 0.
        do_reset();
        cycle(5'b01000, 5'b00000, rand_data(), 1'b0);
        cycle(5'b01000, 5'b00000, rand_data(), 1'b0);
        do_reset();
        cycle(5'b01010, 5'b01010, rand_data(), 1'b0);
        check("post_reset_gid", 64'(grant_id), 64'd1);

        // Randomized traffic with occasional resets.
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            if (n % 300 == 299) do_reset();
            cycle(N'($urandom), N'($urandom & $urandom), rand_data(),
                  ($urandom_range(0, 9) < 4));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
